// File: rtl/miner_if_pkg.sv
// rtl/miner_if_pkg.sv - shared widths and dispatcher state type for the miner host path
package miner_if_pkg;

  localparam int MIDSTATE_W = 256;
  localparam int DATA2_W    = 96;
  localparam int NONCE_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_MINING
  } disp_state_e;

endpackage

// File: rtl/work_dispatcher_if.sv
// rtl/work_dispatcher_if.sv - job, core handshake and nonce stream signals of the dispatcher
interface work_dispatcher_if;
  import miner_if_pkg::*;

  logic                  work_valid;
  logic                  work_ready;
  logic [MIDSTATE_W-1:0] work_midstate;
  logic [DATA2_W-1:0]    work_data2;
  logic [MIDSTATE_W-1:0] midstate;
  logic [DATA2_W-1:0]    data2;
  logic                  start_mining;
  logic                  miner_busy;
  logic                  got_ticket;
  logic [NONCE_W-1:0]    golden_nonce;
  logic                  nonce_valid;
  logic [NONCE_W-1:0]    nonce_data;
  logic                  nonce_ready;
  logic                  job_done;
  logic                  start_fail;
  logic                  overflow;
  logic                  ovf_clr;

  modport slave (
    input  work_valid, work_midstate, work_data2, miner_busy, got_ticket,
    input  golden_nonce, nonce_ready, ovf_clr,
    output work_ready, midstate, data2, start_mining, nonce_valid, nonce_data,
    output job_done, start_fail, overflow
  );

  modport master (
    output work_valid, work_midstate, work_data2, miner_busy, got_ticket,
    output golden_nonce, nonce_ready, ovf_clr,
    input  work_ready, midstate, data2, start_mining, nonce_valid, nonce_data,
    input  job_done, start_fail, overflow
  );

endinterface

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - synchronous golden-nonce FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module nonce_fifo
  import miner_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [NONCE_W-1:0] push_data,
  input  logic               pop,
  output logic [NONCE_W-1:0] head_data,
  output logic               full,
  output logic               empty,
  output logic               drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [NONCE_W-1:0] mem_q [DEPTH];
  logic [NONCE_W-1:0] mem_d [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign drop      = push && full && !do_pop;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/work_dispatcher.sv
// rtl/work_dispatcher.sv - hands one job at a time to the hashing core, tracks its busy
// handshake and queues reported golden nonces for the host.
module work_dispatcher
  import miner_if_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  work_dispatcher_if.slave  bus
);

  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  disp_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MIDSTATE_W-1:0] midstate_q, midstate_d;
  logic [DATA2_W-1:0]    data2_q, data2_d;
  logic                  job_done_q, job_done_d;
  logic                  start_fail_q, start_fail_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_drop;

  nonce_fifo #(.DEPTH(FIFO_DEPTH)) u_nonce_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.got_ticket),
    .push_data (bus.golden_nonce),
    .pop       (bus.nonce_ready && !fifo_empty),
    .head_data (bus.nonce_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    midstate_d   = midstate_q;
    data2_d      = data2_q;
    job_done_d   = 1'b0;
    start_fail_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.work_valid) begin
          midstate_d = bus.work_midstate;
          data2_d    = bus.work_data2;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.miner_busy) begin
          state_d = ST_MINING;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          start_fail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MINING: begin
        if (!bus.miner_busy) begin
          state_d    = ST_IDLE;
          job_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      midstate_q   <= '0;
      data2_q      <= '0;
      job_done_q   <= 1'b0;
      start_fail_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      midstate_q   <= midstate_d;
      data2_q      <= data2_d;
      job_done_q   <= job_done_d;
      start_fail_q <= start_fail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.work_ready   = (state_q == ST_IDLE);
  assign bus.start_mining = (state_q == ST_START);
  assign bus.midstate     = midstate_q;
  assign bus.data2        = data2_q;
  assign bus.job_done     = job_done_q;
  assign bus.start_fail   = start_fail_q;
  assign bus.overflow     = overflow_q;
  assign bus.nonce_valid  = !fifo_empty;

endmodule

// File: doc/work_dispatcher.md
# work_dispatcher

Host-side counterpart of the hashing core: accepts one job (midstate + data2) at a time from the host-facing logic, presents it to the core, issues the start pulse, and tracks the core's busy handshake. Golden nonces reported by the core are captured into a small FIFO and handed back to the host over a valid/ready stream. Sits between the host command decoder and the hashing core.

## Interface
- FIFO_DEPTH, 4: nonce FIFO entries, power of two, ≥2
- BUSY_TIMEOUT, 16: cycles to wait for miner_busy after start_mining before abandoning the job
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- work_valid  input  1  host offers a job
- work_ready  output  1  dispatcher can accept a job (high only in IDLE)
- work_midstate  input  256  job midstate
- work_data2  input  96  job tail data
- midstate  output  256  registered job midstate to core
- data2  output  96  registered job data2 to core
- start_mining  output  1  one-cycle start pulse to core
- miner_busy  input  1  core is hashing
- got_ticket  input  1  core has a golden nonce this cycle
- golden_nonce  input  32  nonce, valid when got_ticket
- nonce_valid  output  1  FIFO head valid
- nonce_data  output  32  FIFO head
- nonce_ready  input  1  host consumes head
- job_done  output  1  one-cycle pulse: core finished job
- start_fail  output  1  one-cycle pulse: busy never seen
- overflow  output  1  sticky: a nonce was dropped
- ovf_clr  input  1  synchronous clear of overflow

## Operation
- States: IDLE, START, WAIT_BUSY, MINING.
- IDLE: work_ready=1. On work_valid: latch work_midstate/work_data2 into midstate/data2 → START.
- START: start_mining=1 for exactly this cycle; clear timeout counter → WAIT_BUSY.
- WAIT_BUSY: miner_busy=1 → MINING. Else if counter = BUSY_TIMEOUT-1 → IDLE with start_fail pulse; else counter+1.
- MINING: miner_busy=0 → IDLE with job_done pulse.
- midstate/data2 change only on acceptance in IDLE; held stable through START, WAIT_BUSY, MINING.
- Nonce capture independent of state: each cycle with got_ticket=1 pushes golden_nonce (a ticket arriving after job_done is still stored).
- Pop when nonce_valid && nonce_ready.
- Full and push without pop: nonce dropped, overflow set. Full with simultaneous push and pop: both performed, no drop.
- Empty with simultaneous push: pushed word appears next cycle (no same-cycle bypass).
- overflow: set by drop, cleared by ovf_clr; set wins if both in same cycle.
- Counters: FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; timeout counter $clog2(BUSY_TIMEOUT) bits.

## Timing
- Reset values: state IDLE, work_ready=1, midstate=0, data2=0, start_mining=0, nonce_valid=0, nonce_data=0, job_done=0, start_fail=0, overflow=0, FIFO empty.
- Reset mid-job: immediate return to IDLE, FIFO flushed, no job_done/start_fail pulse.
- Job accepted at edge T (work_valid && work_ready): midstate/data2 valid and start_mining=1 in cycle after T; work_ready low from T+1 until return to IDLE.
- miner_busy first sampled high at edge T+2 earliest.
- job_done/start_fail asserted in the cycle after the deciding edge; work_ready=1 the same cycle, so a new job can be accepted on that edge.
- got_ticket sampled at edge E → nonce_valid=1 from E+1 (if FIFO was empty).
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package miner_if_pkg: MIDSTATE_W=256, DATA2_W=96, NONCE_W=32, state enum for the four states.
- Sub-module nonce_fifo (synchronous FIFO, width NONCE_W, depth FIFO_DEPTH, push/pop/full/empty/drop); FSM and job registers in work_dispatcher.

## Test plan
- Basic job: midstate=256'h0123…, data2=96'hA5…, core raises busy 3 cycles after start, drops after 100 → one start_mining pulse, outputs match job, job_done once, work_ready back high.
- Tickets: core pulses got_ticket with 32'hDEADBEEF then 32'h00C0FFEE, nonce_ready=1 → nonce_data delivers both in order, nonce_valid drops after.
- Overflow: FIFO_DEPTH=4, nonce_ready=0, 5 tickets → 4 stored (first 4 values), overflow=1; ovf_clr → 0; full + push + pop same cycle → no drop.
- Timeout: miner_busy held 0 → start_fail pulse exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, IDLE, no job_done.
- Back-to-back: work_valid held with second job → second job accepted the cycle job_done is high; midstate unchanged until then.
- Reset mid-MINING with 2 nonces queued → all outputs to reset values, FIFO empty, no pulses.
